// File: rtl/seven_seg_scan_mux.sv
// Two-digit seven-segment scan multiplexer: shares one segment bus between two digits,
// with a per-frame shadow capture of both patterns and a blanking lead-in on every slot.
module seven_seg_scan_mux #(
    parameter int SLOT_CYCLES  = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Enable,
    input  logic [7:0] SevenSegDig1,
    input  logic [7:0] SevenSegDig2,
    output logic [7:0] SegOut,
    output logic [1:0] DigitSel,
    output logic       FrameTick
);

    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST      = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLANK1 = 3'd1,
        SHOW1  = 3'd2,
        BLANK2 = 3'd3,
        SHOW2  = 3'd4
    } state_t;

    state_t        state_p0, state_n;
    logic [CW-1:0] cnt_p0, cnt_n;
    logic [7:0]    shadow1_p0, shadow2_p0;
    logic          capture;

    function automatic logic [7:0] pol_seg(input logic [7:0] lit);
        return (ACTIVE_LOW != 0) ? ~lit : lit;
    endfunction

    function automatic logic [1:0] pol_dig(input logic [1:0] sel);
        return (ACTIVE_LOW != 0) ? ~sel : sel;
    endfunction

    // Stage p0: scan state, slot counter and frame shadows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0   <= IDLE;
            cnt_p0     <= '0;
            shadow1_p0 <= 8'h00;
            shadow2_p0 <= 8'h00;
        end else begin
            state_p0 <= state_n;
            cnt_p0   <= cnt_n;
            if (capture) begin
                shadow1_p0 <= SevenSegDig1;
                shadow2_p0 <= SevenSegDig2;
            end
        end
    end

    always_comb begin
        state_n = state_p0;
        cnt_n   = cnt_p0;
        capture = 1'b0;
        if (state_p0 == IDLE) begin
            cnt_n = '0;
            if (Enable) begin
                state_n = BLANK1;
                capture = 1'b1;
            end
        end else if (!Enable) begin
            // Disable overrides any slot boundary on the same edge
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            cnt_n = (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + 1'b1;
            case (state_p0)
                BLANK1: if (cnt_p0 == CNT_BLANK_END) state_n = SHOW1;
                SHOW1:  if (cnt_p0 == CNT_LAST)      state_n = BLANK2;
                BLANK2: if (cnt_p0 == CNT_BLANK_END) state_n = SHOW2;
                SHOW2: begin
                    if (cnt_p0 == CNT_LAST) begin
                        state_n = BLANK1;
                        capture = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        SegOut    = pol_seg(8'h00);
        DigitSel  = pol_dig(2'b00);
        FrameTick = (state_p0 == BLANK1) && (cnt_p0 == '0);
        case (state_p0)
            SHOW1: begin
                SegOut   = pol_seg(shadow1_p0);
                DigitSel = pol_dig(2'b10);
            end
            SHOW2: begin
                SegOut   = pol_seg(shadow2_p0);
                DigitSel = pol_dig(2'b01);
            end
            default: ;
        endcase
    end

endmodule
